// File: rtl/wide_add_seq.sv
// Multi-cycle wide adder/subtractor: one 16-bit carry-lookahead slice is
// reused for every 16-bit slice of the operands, least-significant first.
// The carry between slices is carried in a register.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for operands, in_ready_o high
// RUN   | one 16-bit slice per cycle, slice index in k_q
// DONE  | result held on sum_o/cout_o/ovf_o, out_valid_o high
module wide_add_seq #(
    parameter int N_SLICES = 4,
    parameter int WIDTH    = 16 * N_SLICES
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    input  logic             cin_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic             busy_o
);

    localparam int KW = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N_SLICES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;     // already inverted for subtraction
    logic             sub_q, sub_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // Shared slice adder operands and results
    logic [15:0] sl_a, sl_b, sl_s;
    logic        sl_co;
    logic [15:0] p, g, c;
    logic [3:0]  gp, gg;
    logic [4:0]  cg;

    logic accept;

    assign accept = (state_q == IDLE) && in_valid_i && !rst_i;

    // Select the current slice of the latched operands
    always_comb begin
        sl_a = a_q[16*k_q +: 16];
        sl_b = b_q[16*k_q +: 16];
    end

    // 16-bit carry-lookahead adder: 4-bit groups with group generate/propagate
    always_comb begin
        p  = sl_a ^ sl_b;
        g  = sl_a & sl_b;
        gp = '0;
        gg = '0;
        cg = '0;
        c  = '0;
        for (int j = 0; j < 4; j++) begin
            gp[j] = &p[4*j +: 4];
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
        end
        cg[0] = carry_q;
        for (int j = 0; j < 4; j++) begin
            cg[j+1] = gg[j] | (gp[j] & cg[j]);
        end
        for (int j = 0; j < 4; j++) begin
            c[4*j] = cg[j];
            for (int i = 0; i < 3; i++) begin
                c[4*j+i+1] = g[4*j+i] | (p[4*j+i] & c[4*j+i]);
            end
        end
        sl_s  = p ^ c;
        sl_co = cg[4];
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = a_i;
                    b_d     = sub_i ? ~b_i : b_i;
                    sub_d   = sub_i;
                    carry_d = sub_i ? 1'b1 : cin_i;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[16*k_q +: 16] = sl_s;
                carry_d             = sl_co;
                if (k_q == K_LAST) begin
                    cout_d  = sl_co;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (sl_s[15] != a_q[WIDTH-1]);
                    k_d     = '0;
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE) && !rst_i;
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign sum_o       = sum_q;
    assign cout_o      = cout_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed bench for wide_add_seq: vector table plus backpressure and
// mid-operation reset sequences.
module tb_wide_add_seq;

    localparam int N = 4;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         sub, cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout, ovf, busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wide_add_seq #(.N_SLICES(N)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_i(a), .b_i(b), .sub_i(sub), .cin_i(cin),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .sum_o(sum), .cout_o(cout), .ovf_o(ovf), .busy_o(busy)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         cin;
        logic [W-1:0] e_sum;
        logic         e_cout;
        logic         e_ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
        end
    endtask

    // Drive operands, wait for in_ready, pass the handshake edge, then
    // scramble the inputs. Returns at the negedge of the first RUN cycle.
    task automatic start(input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vs, input logic vc);
        int guard;
        a = va; b = vb; sub = vs; cin = vc; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); @(negedge clk);
            guard++;
        end
        check("accept_timeout", 64'(guard < 20), 64'd1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        a = ~va; b = 64'h5A5A_A5A5_5A5A_A5A5; sub = ~vs; cin = ~vc;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            check({name, "_busy_run"}, 64'(busy), 64'd1);
            @(posedge clk); @(negedge clk);
            n++;
        end
        check({name, "_latency"}, 64'(n), 64'(N));
    endtask

    task automatic check_res(input string name, input logic [W-1:0] es,
                             input logic ec, input logic eo);
        check({name, "_valid"}, 64'(out_valid), 64'd1);
        check({name, "_sum"},   sum,            es);
        check({name, "_cout"},  64'(cout),      64'(ec));
        check({name, "_ovf"},   64'(ovf),       64'(eo));
        check({name, "_rdy"},   64'(in_ready),  64'd0);
    endtask

    task automatic take(input string name);
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        check({name, "_valid_drop"}, 64'(out_valid), 64'd0);
        check({name, "_idle_rdy"},   64'(in_ready),  64'd1);
    endtask

    initial begin
        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
        vecs[1] = '{64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[2] = '{64'd7, 64'd5, 1'b1, 1'b0, 64'd2, 1'b1, 1'b0};
        vecs[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[4] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        vecs[5] = '{64'h0000_0000_0000_FFFF, 64'd0, 1'b0, 1'b1, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
        vecs[6] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, 64'h2222_2222_2222_2211, 1'b0, 1'b0};
        vecs[7] = '{64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0};
        vecs[8] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1};
        vecs[9] = '{64'd0, 64'd1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rdy",   64'(in_ready),  64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy",  64'(busy),      64'd0);
        check("rst_sum",   sum,            64'd0);
        check("rst_cout",  64'(cout),      64'd0);
        check("rst_ovf",   64'(ovf),       64'd0);
        rst = 1'b0;
        #1;
        check("rdy_after_rst", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Table-driven vectors
        for (int i = 0; i < 10; i++) begin
            start(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin);
            wait_done($sformatf("v%0d", i));
            check_res($sformatf("v%0d", i), vecs[i].e_sum, vecs[i].e_cout, vecs[i].e_ovf);
            take($sformatf("v%0d", i));
        end

        // Backpressure: result held while a new request waits
        start(64'd3, 64'd4, 1'b0, 1'b0);
        wait_done("bp0");
        check_res("bp0", 64'd7, 1'b0, 1'b0);
        a = 64'd100; b = 64'd23; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_sum",   sum,            64'd7);
            check("bp_hold_rdy",   64'(in_ready),  64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        check("bp_idle_valid", 64'(out_valid), 64'd0);
        check("bp_idle_rdy",   64'(in_ready),  64'd1);
        check("bp_idle_busy",  64'(busy),      64'd0);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; a = '1; b = '1;
        wait_done("bp1");
        check_res("bp1", 64'd123, 1'b0, 1'b0);
        take("bp1");

        // Reset during the third RUN cycle
        start(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_rdy", 64'(in_ready), 64'd0);
        @(posedge clk); @(negedge clk);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy",  64'(busy),      64'd0);
        check("mid_rst_sum",   sum,            64'd0);
        check("mid_rst_cout",  64'(cout),      64'd0);
        check("mid_rst_ovf",   64'(ovf),       64'd0);
        rst = 1'b0;
        @(negedge clk);
        start(64'd1, 64'd1, 1'b0, 1'b0);
        wait_done("post_rst");
        check_res("post_rst", 64'd2, 1'b0, 1'b0);
        take("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
